// File: rtl/usb_tx_streamer.sv
// usb_tx_streamer
//   Reads a message from the 256x32 USB TX buffer RAM (second port) and
//   serialises it little-endian, one byte per write strobe, onto an FT-style
//   synchronous FIFO write interface. An Avalon-MM slave sets the length,
//   starts or aborts a transfer and reports progress.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   ctl_address/write/writedata/read/readdata
//                        control slave: 0 CTRL, 1 LEN, 2 COUNT (read latency 0)
//   ram_address          registered TX RAM word address
//   ram_readdata         TX RAM data, valid the cycle after ram_address changes
//   usb_txe_n            FIFO has space when low
//   usb_wr_n, usb_data   registered byte write strobe (active low) and byte
//   irq                  transfer-complete interrupt, only with USB_TX_IRQ_EN
// Build option: define USB_TX_IRQ_EN to add irq and the CTRL bit3 enable.
module usb_tx_streamer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ctl_address,
  input  logic              ctl_write,
  input  logic [31:0]       ctl_writedata,
  input  logic              ctl_read,
  output logic [31:0]       ctl_readdata,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [31:0]       ram_readdata,
  input  logic              usb_txe_n,
  output logic              usb_wr_n,
  output logic [7:0]        usb_data
`ifdef USB_TX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(4 << ADDR_W);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        lane_q, lane_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  xfer_len_q, xfer_len_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              wr_n_q, wr_n_d;
  logic [7:0]        data_q, data_d;
`ifdef USB_TX_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              done_irq_q, done_irq_d;
`endif

  logic             wr_ctrl, wr_len;
  logic             start_cmd, abort_cmd, clr_cmd;
  logic             busy;
  logic             set_done;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] count_inc;
  logic             unused_wdata;

  assign wr_ctrl     = ctl_write && (ctl_address == 2'd0);
  assign wr_len      = ctl_write && (ctl_address == 2'd1);
  assign start_cmd   = wr_ctrl && ctl_writedata[0];
  assign abort_cmd   = wr_ctrl && ctl_writedata[1];
  assign clr_cmd     = wr_ctrl && ctl_writedata[2];
  assign busy        = (state_q != IDLE);
  assign len_clamped = (len_q > MAX_LEN) ? MAX_LEN : len_q;
  assign count_inc   = count_q + LEN_W'(1);
  assign unused_wdata = ^ctl_writedata[31:LEN_W];

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    shift_d    = shift_q;
    lane_d     = lane_q;
    count_d    = count_q;
    xfer_len_d = xfer_len_q;
    len_d      = len_q;
    done_d     = done_q;
    wr_n_d     = 1'b1;
    data_d     = data_q;
    set_done   = 1'b0;

    if (wr_len) len_d = ctl_writedata[LEN_W-1:0];
    if (clr_cmd) done_d = 1'b0;

    if (abort_cmd) begin
      state_d  = IDLE;
      set_done = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_cmd) begin
            count_d = '0;
            if (len_clamped != '0) begin
              xfer_len_d = len_clamped;
              done_d     = 1'b0;
              ram_addr_d = '0;
              state_d    = FETCH;
            end else begin
              set_done = 1'b1;
            end
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          shift_d = ram_readdata;
          lane_d  = '0;
          state_d = SEND;
        end
        SEND: begin
          if (!usb_txe_n) begin
            wr_n_d  = 1'b0;
            data_d  = shift_q[{lane_q, 3'b000} +: 8];
            count_d = count_inc;
            if (count_inc == xfer_len_q) begin
              // last byte of the transfer; a partial last word stops here
              state_d  = IDLE;
              set_done = 1'b1;
            end else if (lane_q == 2'd3) begin
              ram_addr_d = ram_addr_q + ADDR_W'(1);
              state_d    = FETCH;
            end else begin
              lane_d = lane_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (set_done) done_d = 1'b1;
  end

`ifdef USB_TX_IRQ_EN
  always_comb begin
    irq_en_d   = irq_en_q;
    done_irq_d = done_irq_q;
    if (wr_ctrl) irq_en_d = ctl_writedata[3];
    if (clr_cmd) done_irq_d = 1'b0;
    if (set_done) done_irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q   <= 1'b0;
      done_irq_q <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      done_irq_q <= done_irq_d;
    end
  end

  assign irq = done_irq_q & irq_en_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      shift_q    <= '0;
      lane_q     <= '0;
      count_q    <= '0;
      xfer_len_q <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      wr_n_q     <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      shift_q    <= shift_d;
      lane_q     <= lane_d;
      count_q    <= count_d;
      xfer_len_q <= xfer_len_d;
      len_q      <= len_d;
      done_q     <= done_d;
      wr_n_q     <= wr_n_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    ctl_readdata = '0;
    if (ctl_read) begin
      case (ctl_address)
        2'd0: begin
          ctl_readdata[0] = busy;
          ctl_readdata[1] = done_q;
`ifdef USB_TX_IRQ_EN
          ctl_readdata[3] = irq_en_q;
`endif
        end
        2'd1: ctl_readdata[LEN_W-1:0] = len_q;
        2'd2: ctl_readdata[LEN_W-1:0] = count_q;
        default: ctl_readdata = '0;
      endcase
    end
  end

  assign ram_address = ram_addr_q;
  assign usb_wr_n    = wr_n_q;
  assign usb_data    = data_q;

endmodule

// File: tb/tb_usb_tx_streamer.sv
module tb_usb_tx_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ctl_address;
  logic        ctl_write;
  logic [31:0] ctl_writedata;
  logic        ctl_read;
  logic [31:0] ctl_readdata;
  logic [7:0]  ram_address;
  logic [31:0] ram_readdata;
  logic        usb_txe_n;
  logic        usb_wr_n;
  logic [7:0]  usb_data;
`ifdef USB_TX_IRQ_EN
  logic        irq;
`endif

  usb_tx_streamer #(.ADDR_W(8), .LEN_W(11)) dut (
    .clk(clk),
    .reset(reset),
    .ctl_address(ctl_address),
    .ctl_write(ctl_write),
    .ctl_writedata(ctl_writedata),
    .ctl_read(ctl_read),
    .ctl_readdata(ctl_readdata),
    .ram_address(ram_address),
    .ram_readdata(ram_readdata),
    .usb_txe_n(usb_txe_n),
    .usb_wr_n(usb_wr_n),
    .usb_data(usb_data)
`ifdef USB_TX_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // TX RAM model: one-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) ram_readdata <= mem[ram_address];

  int   cyc = 0;
  logic txe_prev = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    txe_prev <= usb_txe_n;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: bytes still owed to the FIFO, in order
  logic [7:0]  exp_q[$];
  int          pulse_cnt = 0;
  int          start_cyc = 0;
  int          run_len   = 0;
  int          cur_eff   = 0;
  bit          all_low   = 1'b0;
  bit          txe_rand  = 1'b0;
  logic [31:0] ien       = '0;

  // write-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && usb_wr_n === 1'b0) begin
        check_eq("wr_after_txe_hi", txe_prev, 0);
        run_len++;
        check_eq("wr_run_le4", run_len <= 4, 1);
        if (exp_q.size() == 0) check_eq("wr_unexpected", usb_wr_n, 1);
        else check_eq("wr_byte", usb_data, exp_q.pop_front());
        // with txe_n low throughout: byte i lands 4 + i + 2*(i/4) cycles after start
        if (all_low) check_eq("wr_cycle", cyc - start_cyc, 4 + pulse_cnt + 2 * (pulse_cnt / 4));
        pulse_cnt++;
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    if (txe_rand) usb_txe_n = ($urandom_range(0, 3) == 0);
  endtask

  task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
    ctl_address   = a;
    ctl_writedata = d;
    ctl_write     = 1'b1;
    step();
    ctl_write     = 1'b0;
  endtask

  task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
    ctl_address = a;
    ctl_read    = 1'b1;
    #1;
    d           = ctl_readdata;
    ctl_read    = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int k;
    k = 0;
    while (pulse_cnt < n && k < 200) begin
      step();
      k++;
    end
    check_eq("wait_pulses", pulse_cnt >= n, 1);
  endtask

  task automatic start_xfer(input int len_reg, input bit rand_txe);
    logic [31:0] w;
    logic [31:0] d;
    int eff;
    eff     = (len_reg > 1024) ? 1024 : len_reg;
    cur_eff = eff;
    exp_q.delete();
    for (int i = 0; i < eff; i++) begin
      w = mem[i / 4];
      exp_q.push_back(w[8 * (i % 4) +: 8]);
    end
    ctl_wr(2'd1, 32'(len_reg));
    pulse_cnt = 0;
    all_low   = !rand_txe;
    txe_rand  = rand_txe;
    if (!rand_txe) usb_txe_n = 1'b0;
    start_cyc = cyc;
    ctl_wr(2'd0, 32'h1 | ien);
    ctl_rd(2'd0, d);
    if (eff > 0) begin
      check_eq("start_addr", ram_address, 0);
      check_eq("start_busy", d[1:0], 2'b01);
    end else begin
      check_eq("len0_done", d[1:0], 2'b10);
    end
  endtask

  task automatic finish_xfer();
    logic [31:0] d;
    int n;
    n = 0;
    d = 32'h1;
    while (n < 4000) begin
      ctl_rd(2'd0, d);
      if (d[0] == 1'b0) break;
      step();
      n++;
    end
    check_eq("idle_reached", d[0], 0);
    step();
    ctl_rd(2'd0, d);
    check_eq("done_set", d[1], 1);
    ctl_rd(2'd2, d);
    check_eq("count_final", d, cur_eff);
    check_eq("bytes_left", exp_q.size(), 0);
    if (cur_eff > 0) check_eq("ram_addr_final", ram_address, (cur_eff - 1) / 4);
  endtask

  task automatic run_xfer(input int len_reg, input bit rand_txe);
    start_xfer(len_reg, rand_txe);
    finish_xfer();
  endtask

  initial begin
    logic [31:0] d;
    int pc;

    reset         = 1'b1;
    ctl_address   = '0;
    ctl_write     = 1'b0;
    ctl_writedata = '0;
    ctl_read      = 1'b0;
    usb_txe_n     = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    tick();
    tick();
    check_eq("rst_wr_n", usb_wr_n, 1);
    check_eq("rst_data", usb_data, 0);
    check_eq("rst_ram_addr", ram_address, 0);
    check_eq("rst_readdata", ctl_readdata, 0);
`ifdef USB_TX_IRQ_EN
    check_eq("rst_irq", irq, 0);
`endif
    reset = 1'b0;
    tick();
    ctl_rd(2'd0, d);
    check_eq("rst_ctrl", d, 0);
    ctl_rd(2'd1, d);
    check_eq("rst_len", d, 0);
    tick();
    ctl_rd(2'd2, d);
    check_eq("rst_count", d, 0);

    // single full word
    mem[0] = 32'h44332211;
    run_xfer(4, 1'b0);

    // partial second word, fetch gap after the fourth byte
    mem[1] = 32'h88776655;
    run_xfer(6, 1'b0);

    // FIFO full for five cycles mid-word
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    start_xfer(8, 1'b0);
    all_low = 1'b0;
    wait_pulses(2);
    usb_txe_n = 1'b1;
    pc = pulse_cnt;
    repeat (5) step();
    check_eq("txe_hold_nopulse", pulse_cnt, pc);
    usb_txe_n = 1'b0;
    finish_xfer();

    // abort after three bytes, with an ignored start while busy
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    start_xfer(16, 1'b0);
    wait_pulses(1);
    ctl_wr(2'd0, 32'h1 | ien);
    wait_pulses(3);
    ctl_wr(2'd0, 32'h2 | ien);
    check_eq("abort_wr_n", usb_wr_n, 1);
    exp_q.delete();
    ctl_rd(2'd0, d);
    check_eq("abort_status", d[1:0], 2'b10);
    ctl_rd(2'd2, d);
    check_eq("abort_count", d, 3);
    repeat (8) step();
    check_eq("abort_pulses", pulse_cnt, 3);

    // abort and start in one write: abort wins
    ctl_wr(2'd0, 32'h4 | ien);
    ctl_wr(2'd1, 32'd8);
    pulse_cnt = 0;
    ctl_wr(2'd0, 32'h3 | ien);
    ctl_rd(2'd0, d);
    check_eq("abort_start_status", d[1:0], 2'b10);
    repeat (6) step();
    check_eq("abort_start_pulses", pulse_cnt, 0);

    // zero length
    ctl_wr(2'd0, 32'h4 | ien);
    ctl_rd(2'd0, d);
    check_eq("done_cleared", d[1], 0);
    start_xfer(0, 1'b0);
    repeat (6) step();
    check_eq("len0_pulses", pulse_cnt, 0);
    ctl_rd(2'd2, d);
    check_eq("len0_count", d, 0);

    // oversize length clamps to the whole RAM
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    run_xfer(2000, 1'b0);

    // randomized lengths and FIFO back-pressure
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_xfer($urandom_range(1, 40), 1'b1);
    end
    txe_rand  = 1'b0;
    usb_txe_n = 1'b0;

    // interrupt enable bit
    ctl_wr(2'd0, 32'h8);
    ctl_rd(2'd0, d);
`ifdef USB_TX_IRQ_EN
    check_eq("ien_readback", d[3], 1);
    ien = 32'h8;
    run_xfer(4, 1'b0);
    check_eq("irq_set", irq, 1);
    ctl_wr(2'd0, 32'h4 | ien);
    check_eq("irq_clear", irq, 0);
    run_xfer(4, 1'b0);
    check_eq("irq_set_again", irq, 1);
`else
    check_eq("ien_absent", d[3], 0);
`endif

    // reset in the middle of a transfer
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    start_xfer(16, 1'b0);
    all_low = 1'b0;
    wait_pulses(2);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_wr_n", usb_wr_n, 1);
    check_eq("mid_rst_data", usb_data, 0);
    check_eq("mid_rst_ram_addr", ram_address, 0);
`ifdef USB_TX_IRQ_EN
    check_eq("mid_rst_irq", irq, 0);
`endif
    ctl_rd(2'd2, d);
    check_eq("mid_rst_count", d, 0);
    exp_q.delete();
    pc = pulse_cnt;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) step();
    check_eq("post_rst_pulses", pulse_cnt, pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
